// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_buffer
// Brief    : Packs a high-byte-first instruction byte stream into 16-bit
//            words, tags each word with its program address and queues it in
//            a first-word-fall-through FIFO for the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [15:0]              instr_out,
  output logic [PC_W-1:0]          instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     flush,
  input  logic [PC_W-1:0]          flush_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  localparam logic [0:0] ST_HI = 1'b0;
  localparam logic [0:0] ST_LO = 1'b1;

  logic [0:0]      r_state;
  logic [7:0]      r_hi;
  logic [PC_W-1:0] r_next_pc;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_mem_word [DEPTH];
  logic [PC_W-1:0] r_mem_pc   [DEPTH];

  logic w_accept;
  logic w_push;
  logic w_pop;

  // In LO the ready is judged on the pre-pop count, hence a bubble when full.
  assign byte_ready  = !flush && ((r_state == ST_HI) || (r_count < C_FULL));
  assign w_accept    = byte_valid && byte_ready;
  assign w_push      = w_accept && (r_state == ST_LO);
  assign instr_valid = (r_count != '0);
  assign w_pop       = !flush && instr_valid && instr_ready;

  assign instr_out  = instr_valid ? r_mem_word[r_rptr] : 16'h0000;
  assign instr_pc   = instr_valid ? r_mem_pc[r_rptr]   : '0;
  assign fifo_count = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_HI;
      r_hi      <= 8'h00;
      r_next_pc <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else if (flush) begin
      r_state   <= ST_HI;
      r_next_pc <= flush_pc;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_HI) begin
          r_hi    <= byte_in;
          r_state <= ST_LO;
        end else begin
          r_next_pc <= r_next_pc + PC_W'(1);
          r_state   <= ST_HI;
        end
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is governed solely by the count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_word[r_wptr] <= {r_hi, byte_in};
      r_mem_pc[r_wptr]   <= r_next_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_buffer
// Brief    : Self-checking bench for instr_prefetch_buffer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;
  localparam int PC_W  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      byte_in = 8'h00;
  logic            byte_valid = 1'b0;
  logic            byte_ready;
  logic [15:0]     instr_out;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic            flush = 1'b0;
  logic [PC_W-1:0] flush_pc = '0;
  logic [2:0]      fifo_count;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {pc, word}, plus an optional pending high byte.
  logic [18:0] q[$];
  bit          have_hi;
  logic [7:0]  hi_byte;
  int          npc;
  bit          last_acc;
  logic [7:0]  nb;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    have_hi = 0;
    hi_byte = 8'h00;
    npc     = 0;
  endtask

  function automatic logic exp_ready(input logic fl);
    return !fl && (!have_hi || q.size() < DEPTH);
  endfunction

  task automatic check_outputs(input logic fl);
    logic        v;
    logic [18:0] h;
    v = (q.size() != 0);
    h = v ? q[0] : 19'h0;
    chk("byte_ready",  {31'h0, byte_ready},  {31'h0, exp_ready(fl)});
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, v});
    chk("instr_out",   {16'h0, instr_out},   {16'h0, h[15:0]});
    chk("instr_pc",    {29'h0, instr_pc},    {29'h0, h[18:16]});
    chk("fifo_count",  {29'h0, fifo_count},  q.size());
  endtask

  // One clock: drive at negedge, check before the rising edge, update model.
  task automatic step(input logic bv, input logic [7:0] b, input logic rdy,
                      input logic fl, input logic [PC_W-1:0] fpc);
    bit acc, pop;
    byte_valid  = bv;
    byte_in     = b;
    instr_ready = rdy;
    flush       = fl;
    flush_pc    = fpc;
    #1;
    check_outputs(fl);
    acc = bv && exp_ready(fl);
    pop = !fl && rdy && (q.size() != 0);
    if (fl) begin
      q.delete();
      have_hi = 0;
      npc     = fpc;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (!have_hi) begin
          hi_byte = b;
          have_hi = 1;
        end else begin
          q.push_back({npc[PC_W-1:0], hi_byte, b});
          npc     = (npc + 1) % (1 << PC_W);
          have_hi = 0;
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Streams n incrementing bytes, holding each until accepted.
  task automatic stream(input int n, input logic rdy);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      step(1'b1, nb, rdy, 1'b0, '0);
      if (last_acc) begin
        got++;
        nb = nb + 8'h11;
      end
      cyc++;
    end
    chk("stream_accepted", got, n);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0, '0);
  endtask

  initial begin
    model_reset();
    nb = 8'h01;
    @(negedge clk);
    #1;
    chk("reset_valid", {31'h0, instr_valid}, 0);
    chk("reset_count", {29'h0, fifo_count}, 0);
    chk("reset_out",   {16'h0, instr_out}, 0);
    chk("reset_pc",    {29'h0, instr_pc}, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1, 1'b0);

    // Basic pair assembly with consumer always ready.
    step(1'b1, 8'h12, 1'b1, 1'b0, '0);
    step(1'b1, 8'h34, 1'b1, 1'b0, '0);
    chk("first_word", {16'h0, instr_out}, 32'h1234);
    step(1'b1, 8'h56, 1'b1, 1'b0, '0);
    step(1'b1, 8'h78, 1'b1, 1'b0, '0);
    chk("second_word", {16'h0, instr_out}, 32'h5678);
    chk("second_pc", {29'h0, instr_pc}, 1);
    idle(2, 1'b1);

    // Fill the FIFO, stall in LO, then release one slot.
    stream(9, 1'b0);
    chk("full_count", {29'h0, fifo_count}, DEPTH);
    step(1'b1, nb, 1'b0, 1'b0, '0);
    chk("stall_no_accept", {31'h0, last_acc}, 0);
    step(1'b1, nb, 1'b1, 1'b0, '0);
    chk("bubble_no_accept", {31'h0, last_acc}, 0);
    step(1'b1, nb, 1'b0, 1'b0, '0);
    chk("after_pop_accept", {31'h0, last_acc}, 1);
    nb = nb + 8'h11;
    idle(6, 1'b1);

    // Simultaneous push and pop with two words queued.
    stream(4, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, '0);
    step(1'b1, 8'h3C, 1'b1, 1'b0, '0);
    chk("pushpop_count", {29'h0, fifo_count}, 2);
    idle(3, 1'b1);

    // Tag wrap across 16 words.
    step(1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
    stream(32, 1'b1);
    idle(2, 1'b1);

    // Flush while holding a high byte.
    step(1'b1, 8'hAA, 1'b0, 1'b0, '0);
    step(1'b1, 8'h9C, 1'b1, 1'b1, 3'd5);
    chk("flush_no_accept", {31'h0, last_acc}, 0);
    step(1'b1, 8'h9C, 1'b0, 1'b0, '0);
    step(1'b1, 8'h01, 1'b0, 1'b0, '0);
    chk("flush_word", {16'h0, instr_out}, 32'h9C01);
    chk("flush_pc", {29'h0, instr_pc}, 5);
    idle(2, 1'b1);

    // Asynchronous reset with three words queued and a half word held.
    stream(7, 1'b0);
    chk("pre_reset_count", {29'h0, fifo_count}, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", {31'h0, instr_valid}, 0);
    chk("async_count", {29'h0, fifo_count}, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h4D, 1'b0, 1'b0, '0);
    step(1'b1, 8'hE2, 1'b0, 1'b0, '0);
    chk("post_reset_word", {16'h0, instr_out}, 32'h4DE2);
    chk("post_reset_pc", {29'h0, instr_pc}, 0);

    // Randomized traffic with occasional flushes.
    nb = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      logic fl;
      fl = ($urandom_range(0, 19) == 0);
      step(1'($urandom), nb, 1'($urandom), fl, 3'($urandom));
      if (last_acc) nb = 8'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
